// File: rtl/imem_loader.sv
// Framed byte-stream loader: [count_hi, count_lo, count*4 big-endian word bytes] -> imem writes.
// Define IMEM_LOADER_CHECKSUM_EN to expect one trailing XOR-of-frame checksum byte.
module imem_loader #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone
  } state_e;

  // State entered once the header/data portion of a frame is exhausted.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e StTail = StCsum;
`else
  localparam state_e StTail = StDone;
`endif

  state_e             state_q, state_d;
  logic [7:0]         hdr_hi_q, hdr_hi_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        word_q, word_d;
  logic               byte_ready_q, byte_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif
  logic               accept;

  assign accept = byte_valid && byte_ready_q;

  always_comb begin
    state_d   = state_q;
    hdr_hi_d  = hdr_hi_q;
    count_d   = count_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    if (accept) csum_d = csum_q ^ byte_data;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (load_start) begin
          state_d = StHdr0;
          err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      StHdr0: begin
        if (accept) begin
          hdr_hi_d = byte_data;
          state_d  = StHdr1;
        end
      end
      StHdr1: begin
        if (accept) begin
          count_d = CNT_W'({hdr_hi_q, byte_data});
          idx_d   = '0;
          lane_d  = 2'd0;
          state_d = (count_d == '0) ? StTail : StData;
        end
      end
      StData: begin
        if (accept) begin
          word_d = {word_q[23:0], byte_data};
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            // Words past the end of memory are consumed but only flagged.
            if (32'(idx_q) < DEPTH) begin
              wr_en_d   = 1'b1;
              wr_addr_d = 32'({idx_q, 2'b00});
              wr_data_d = word_d;
            end else begin
              err_d = 1'b1;
            end
            idx_d = idx_q + CNT_W'(1);
            if (idx_d == count_q) state_d = StTail;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          if (byte_data != csum_q) err_d = 1'b1;
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    byte_ready_d = (state_d == StHdr0) || (state_d == StHdr1) || (state_d == StData)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_d == StCsum)
`endif
                   ;
    cpu_hold_d   = (state_d != StIdle) && (state_d != StDone);
    done_d       = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      hdr_hi_q     <= 8'h00;
      count_q      <= '0;
      idx_q        <= '0;
      lane_q       <= 2'd0;
      word_q       <= 32'h0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 32'h0;
      wr_data_q    <= 32'h0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      hdr_hi_q     <= hdr_hi_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
